// File: rtl/axi_bank_scheduler.sv
// Line-buffer bank scheduler: hands BRAM banks to a stream writer and an undistort reader in strict FIFO order.
// Latency: a grant or release takes effect on the edge after the req/done; full_count and bank_select are registered.
// Backpressure: the writer stalls (sticky overflow) on a non-FREE bank; AXI_BANK_SCHED_OVERWRITE_EN reclaims the oldest FULL bank instead.
module axi_bank_scheduler #(
    parameter int NUM_BANKS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 frame_start,
    input  logic                 wr_req,
    input  logic                 wr_done,
    output logic                 wr_grant,
    output logic [IDX_W-1:0]     wr_bank,
    input  logic                 rd_req,
    input  logic                 rd_done,
    output logic                 rd_grant,
    output logic [IDX_W-1:0]     rd_bank,
    output logic [NUM_BANKS-1:0] bank_select,
    output logic [IDX_W:0]       full_count,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    bank_state_t          bank_q [NUM_BANKS];
    bank_state_t          bank_d [NUM_BANKS];
    logic [IDX_W-1:0]     wp_q, wp_d;
    logic [IDX_W-1:0]     rp_q, rp_d;
    logic                 wr_grant_d, rd_grant_d;
    logic [IDX_W-1:0]     wr_bank_d, rd_bank_d;
    logic [NUM_BANKS-1:0] bank_select_d;
    logic [IDX_W:0]       full_count_d;
    logic                 overflow_d;
    logic [7:0]           drop_count_d;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_BANKS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                bank_q[k] <= FREE;
            end
            wp_q        <= '0;
            rp_q        <= '0;
            wr_grant    <= 1'b0;
            rd_grant    <= 1'b0;
            wr_bank     <= '0;
            rd_bank     <= '0;
            bank_select <= '0;
            full_count  <= '0;
            overflow    <= 1'b0;
            drop_count  <= 8'd0;
        end else begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                bank_q[k] <= bank_d[k];
            end
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            wr_grant    <= wr_grant_d;
            rd_grant    <= rd_grant_d;
            wr_bank     <= wr_bank_d;
            rd_bank     <= rd_bank_d;
            bank_select <= bank_select_d;
            full_count  <= full_count_d;
            overflow    <= overflow_d;
            drop_count  <= drop_count_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_BANKS; k++) begin
            bank_d[k] = bank_q[k];
        end
        wp_d          = wp_q;
        rp_d          = rp_q;
        wr_grant_d    = wr_grant;
        rd_grant_d    = rd_grant;
        wr_bank_d     = wr_bank;
        rd_bank_d     = rd_bank;
        overflow_d    = overflow;
        drop_count_d  = drop_count;
        bank_select_d = '0;
        full_count_d  = '0;

        if (frame_start) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                bank_d[k] = FREE;
            end
            wp_d       = '0;
            rp_d       = '0;
            wr_grant_d = 1'b0;
            rd_grant_d = 1'b0;
            wr_bank_d  = '0;
            rd_bank_d  = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_grant) begin
                if (wr_done) begin
                    bank_d[wr_bank] = FULL;
                    wr_grant_d      = 1'b0;
                    wp_d            = next_idx(wp_q);
                end
            end else if (wr_req) begin
                if (bank_q[wp_q] == FREE) begin
                    bank_d[wp_q] = WRITING;
                    wr_grant_d   = 1'b1;
                    wr_bank_d    = wp_q;
                end else begin
                    overflow_d = 1'b1;
`ifdef AXI_BANK_SCHED_OVERWRITE_EN
                    // A read grant on the same bank this cycle wins; the drop is avoided.
                    if (bank_q[wp_q] == FULL && !(rd_req && !rd_grant && rp_q == wp_q)) begin
                        bank_d[wp_q] = WRITING;
                        wr_grant_d   = 1'b1;
                        wr_bank_d    = wp_q;
                        rp_d         = next_idx(rp_q);
                        if (drop_count != 8'hFF) begin
                            drop_count_d = drop_count + 8'd1;
                        end
                    end
`endif
                end
            end

            if (rd_grant) begin
                if (rd_done) begin
                    bank_d[rd_bank] = FREE;
                    rd_grant_d      = 1'b0;
                    rp_d            = next_idx(rp_q);
                end
            end else if (rd_req && bank_q[rp_q] == FULL) begin
                bank_d[rp_q] = READING;
                rd_grant_d   = 1'b1;
                rd_bank_d    = rp_q;
            end
        end

        // Outputs derive from next state so they register in step with the banks.
        for (int k = 0; k < NUM_BANKS; k++) begin
            bank_select_d[k] = (bank_d[k] == WRITING);
            if (bank_d[k] == FULL) begin
                full_count_d = full_count_d + {{IDX_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_axi_bank_scheduler.sv
// Directed bench for axi_bank_scheduler (default build, NUM_BANKS=4).
module tb_axi_bank_scheduler;

    logic       ACLK = 1'b0;
    logic       ARESETn = 1'b0;
    logic       frame_start = 1'b0;
    logic       wr_req = 1'b0;
    logic       wr_done = 1'b0;
    logic       rd_req = 1'b0;
    logic       rd_done = 1'b0;
    logic       wr_grant, rd_grant, overflow;
    logic [1:0] wr_bank, rd_bank;
    logic [3:0] bank_select;
    logic [2:0] full_count;
    logic [7:0] drop_count;

    int n_chk = 0;
    int n_err = 0;

    axi_bank_scheduler #(.NUM_BANKS(4), .IDX_W(2)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .frame_start (frame_start),
        .wr_req      (wr_req),
        .wr_done     (wr_done),
        .wr_grant    (wr_grant),
        .wr_bank     (wr_bank),
        .rd_req      (rd_req),
        .rd_done     (rd_done),
        .rd_grant    (rd_grant),
        .rd_bank     (rd_bank),
        .bank_select (bank_select),
        .full_count  (full_count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write();
        wr_req = 1'b1;
        tick();
        wr_req  = 1'b0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] exp_bank, input string tag);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk({tag, "_grant"}, 32'(rd_grant), 32'd1);
        chk({tag, "_bank"}, 32'(rd_bank), 32'(exp_bank));
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk({tag, "_released"}, 32'(rd_grant), 32'd0);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_wr_grant", 32'(wr_grant), 32'd0);
        chk("rst_rd_grant", 32'(rd_grant), 32'd0);
        chk("rst_wr_bank", 32'(wr_bank), 32'd0);
        chk("rst_rd_bank", 32'(rd_bank), 32'd0);
        chk("rst_bank_select", 32'(bank_select), 32'd0);
        chk("rst_full_count", 32'(full_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        #2 ARESETn = 1'b1;

        // First write: grant one cycle after request, release to FULL
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("w0_grant", 32'(wr_grant), 32'd1);
        chk("w0_bank", 32'(wr_bank), 32'd0);
        chk("w0_select", 32'(bank_select), 32'h1);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("w0_done_grant", 32'(wr_grant), 32'd0);
        chk("w0_done_full", 32'(full_count), 32'd1);
        chk("w0_done_select", 32'(bank_select), 32'h0);

        // Fill banks 1,2 then read twice in FIFO order
        do_write();
        do_write();
        chk("fill3_full", 32'(full_count), 32'd3);
        do_read(2'd0, "rd_a");
        do_read(2'd1, "rd_b");
        chk("after2rd_full", 32'(full_count), 32'd1);

        // Writer (bank 3) and reader (bank 2) granted in the same cycle
        wr_req = 1'b1;
        rd_req = 1'b1;
        tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        chk("conc_wr_bank", 32'(wr_bank), 32'd3);
        chk("conc_rd_bank", 32'(rd_bank), 32'd2);
        chk("conc_select", 32'(bank_select), 32'h8);
        chk("conc_full", 32'(full_count), 32'd0);
        wr_done = 1'b1;
        rd_done = 1'b1;
        tick();
        wr_done = 1'b0;
        rd_done = 1'b0;
        chk("conc_done_full", 32'(full_count), 32'd1);
        chk("conc_done_grants", 32'({wr_grant, rd_grant}), 32'd0);
        chk("pre_stall_overflow", 32'(overflow), 32'd0);

        // All four banks FULL: writer stalls, overflow sticks
        do_write();
        do_write();
        do_write();
        chk("all_full", 32'(full_count), 32'd4);
        wr_req = 1'b1;
        tick();
        chk("stall_grant", 32'(wr_grant), 32'd0);
        chk("stall_overflow", 32'(overflow), 32'd1);
        tick();
        wr_req = 1'b0;
        chk("stall_grant2", 32'(wr_grant), 32'd0);
        tick();
        chk("overflow_sticky", 32'(overflow), 32'd1);
        chk("stall_drop", 32'(drop_count), 32'd0);
        chk("stall_full", 32'(full_count), 32'd4);

        // Oldest FULL bank is 3; free it, then both sides take a grant
        do_read(2'd3, "rd_c");
        chk("rd_c_full", 32'(full_count), 32'd3);
        wr_req = 1'b1;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("hold_wr_bank", 32'(wr_bank), 32'd3);
        chk("hold_rd_bank", 32'(rd_bank), 32'd0);
        chk("hold_grants", 32'({wr_grant, rd_grant}), 32'h3);

        // frame_start flushes; held wr_req granted bank 0 two cycles after pulse
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("fs_grants", 32'({wr_grant, rd_grant}), 32'd0);
        chk("fs_full", 32'(full_count), 32'd0);
        chk("fs_overflow", 32'(overflow), 32'd0);
        chk("fs_select", 32'(bank_select), 32'h0);
        tick();
        wr_req = 1'b0;
        chk("fs_regrant", 32'(wr_grant), 32'd1);
        chk("fs_regrant_bank", 32'(wr_bank), 32'd0);

        // Simultaneous wr_done (bank 1) and rd_done (bank 0)
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("b0_full", 32'(full_count), 32'd1);
        wr_req = 1'b1;
        rd_req = 1'b1;
        tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        chk("sim_wr_bank", 32'(wr_bank), 32'd1);
        chk("sim_rd_bank", 32'(rd_bank), 32'd0);
        chk("sim_select", 32'(bank_select), 32'h2);
        wr_done = 1'b1;
        rd_done = 1'b1;
        tick();
        wr_done = 1'b0;
        rd_done = 1'b0;
        chk("sim_done_full", 32'(full_count), 32'd1);
        chk("sim_done_grants", 32'({wr_grant, rd_grant}), 32'd0);
        chk("sim_done_select", 32'(bank_select), 32'h0);

        // Asynchronous reset mid-transfer
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("pre_rst_grant", 32'(wr_grant), 32'd1);
        chk("pre_rst_bank", 32'(wr_bank), 32'd2);
        #2 ARESETn = 1'b0;
        #1;
        chk("arst_wr_grant", 32'(wr_grant), 32'd0);
        chk("arst_wr_bank", 32'(wr_bank), 32'd0);
        chk("arst_full", 32'(full_count), 32'd0);
        chk("arst_select", 32'(bank_select), 32'h0);
        @(posedge ACLK);
        #3 ARESETn = 1'b1;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("late_done_grant", 32'(wr_grant), 32'd0);
        chk("late_done_full", 32'(full_count), 32'd0);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("post_rst_grant", 32'(wr_grant), 32'd1);
        chk("post_rst_bank", 32'(wr_bank), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
